// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from a UART receiver's ready/clear handshake into a FIFO.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_ready,
  input  logic [WIDTH-1:0]         rx_data,
  output logic                     rx_ready_clr,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, CLR} state_t;
  state_t           state_q, state_d;
  logic             clr_q, ovf_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop, wr, drop;
  assign empty    = count_q == '0;
  assign full     = count_q == CW'(DEPTH);
  assign push     = state_q == IDLE && rx_ready;
  assign pop      = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a write into a full FIFO still succeeds
  assign wr       = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign count_d  = count_q + CW'(wr) - CW'(pop);
  assign state_d  = push ? CLR : (state_q == CLR && !rx_ready) ? IDLE : state_q;
  assign rx_ready_clr = clr_q;
  assign overflow = ovf_q;
  assign count    = count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      clr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      clr_q    <= state_d == CLR;
      ovf_q    <= drop || (ovf_q && !ovf_clr);
      wr_ptr_q <= wr_ptr_q + AW'(wr);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
    end
  always_ff @(posedge clk)
    if (wr && !rst) mem_q[wr_ptr_q] <= rx_data;
`ifdef UART_RX_FIFO_FWFT_EN
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];
    end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter WIDTH, default 8, bits per entry; SHALL match the receiver's data output width.
REQ-003 Port clk  in  1  the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port rx_ready  in  1  receiver byte-available flag, held high until cleared.
REQ-006 Port rx_data  in  WIDTH  received byte, stable while rx_ready is high.
REQ-007 Port rx_ready_clr  out  1  clear request to the receiver's ready_clr input.
REQ-008 Port rd_en  in  1  consumer pop request.
REQ-009 Port rd_data  out  WIDTH  head-of-queue data.
REQ-010 Port rd_valid  out  1  rd_data qualifier.
REQ-011 Port empty  out  1  count == 0.
REQ-012 Port full  out  1  count == DEPTH.
REQ-013 Port count  out  clog2(DEPTH)+1  current occupancy.
REQ-014 Port overflow  out  1  sticky dropped-byte flag.
REQ-015 Port ovf_clr  in  1  synchronous clear for overflow.

Function
REQ-016 Capture FSM SHALL have states IDLE, CLR.
REQ-017 IDLE with rx_ready=1: SHALL write rx_data at the write pointer if not full; transition to CLR on the same edge.
REQ-018 CLR: rx_ready_clr SHALL be 1; SHALL return to IDLE on the first edge where rx_ready=0; no write SHALL occur in CLR.
REQ-019 rx_ready_clr SHALL be 0 in IDLE; each received byte SHALL be written exactly once.
REQ-020 IDLE with rx_ready=1 and full=1 with no accepted pop that cycle: byte SHALL be dropped; overflow SHALL be set; FSM SHALL still go to CLR.
REQ-021 Write and accepted pop in the same cycle when full: write SHALL succeed; count SHALL be unchanged; overflow SHALL NOT be set.
REQ-022 A pop SHALL be accepted only when rd_en=1 and empty=0; rd_en while empty SHALL be ignored with no state change.
REQ-023 Simultaneous write and pop at any occupancy SHALL leave count unchanged and advance both pointers.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 full and empty SHALL be registered-state derived, valid in the cycle after the edge that changes count.
REQ-026 ovf_clr=1 SHALL clear overflow; if a new overflow event occurs in the same cycle, overflow SHALL remain 1 (set wins).

Reset
REQ-027 rst=1 SHALL asynchronously force FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, rx_ready_clr=0, rd_valid=0, rd_data=0.
REQ-028 Reset mid-CLR SHALL discard the handshake; after release, a still-high rx_ready SHALL be captured as a new byte.
REQ-029 Memory contents SHALL NOT be reset; they SHALL be unobservable until written.

Configuration
REQ-030 Macro UART_RX_FIFO_FWFT_EN SHALL select read mode.
REQ-031 Defined (first-word-fall-through): rd_data SHALL show the head entry whenever empty=0; rd_valid = !empty; rd_en pops the head; the next entry SHALL appear on the following cycle.
REQ-032 Undefined (registered): an accepted pop SHALL load rd_data on that edge; rd_valid SHALL be a 1-cycle pulse the next cycle; rd_data SHALL hold its value otherwise.

Verification
REQ-033 Single byte: rx_data=0x05, rx_ready high until rx_ready_clr, then low -> exactly one write, count=1, rx_ready_clr high only in CLR, FSM back in IDLE.
REQ-034 Fill: 8 bytes 0x01..0x08 with DEPTH=8 -> full=1, count=8; 9th byte 0x09 -> overflow=1, count=8; pop all -> 0x01..0x08 in order, empty=1.
REQ-035 Full plus simultaneous pop and write 0x0A -> overflow stays 0, count=8, 0x0A is the last byte popped.
REQ-036 Read latency: pop in FWFT build -> rd_data valid the same cycle; non-FWFT build -> rd_valid pulse one cycle after rd_en with the correct byte.
REQ-037 Reset asserted during CLR with rx_ready high -> all outputs at reset values immediately; after release the byte is captured once, count=1.
REQ-038 Wrap: push/pop 20 bytes 0x00..0x13 interleaved -> output order preserved across pointer wrap; rd_en while empty has no effect.
